forward_stall_unit: RTL

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/forward_stall_unit_fwd_match.sv | 24 ++
 rtl/forward_stall_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and
// the hazard scoreboard entry layout.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t dst;
    logic     wen;
    logic     load;
  } sb_entry_t;

  function automatic logic src_match(
    input logic      used,
    input regbits_t  idx,
    input sb_entry_t e
  );
    return used & e.valid & e.wen &
           (idx == e.dst) & (idx != '0);
  endfunction

endpackage

// File: rtl/forward_stall_unit_fwd_match.sv
// Per-source forwarding comparator: picks the
// youngest stage (smallest k >= 1) producing idx.
module fwd_match
  import cpu_types_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int SEL_W  = 2
) (
  input  logic                   used,
  input  regbits_t               idx,
  input  sb_entry_t [NSTAGE-1:0] sb,
  output logic [SEL_W-1:0]       sel
);

  always_comb begin
    sel = '0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (src_match(used, idx, sb[k])) begin
        sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/forward_stall_unit.sv
// Load-use stall detection and EX operand forward
// select for an in-order pipeline.
module forward_stall_unit
  import cpu_types_pkg::*;
#(
  parameter int NSRC     = 2,
  parameter int NSTAGE   = 3,
  parameter int LOAD_FWD = 2,
  parameter int CNT_W    = 16,
  localparam int SEL_W   =
    (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       advance,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NSRC-1:0][REG_W-1:0] id_src,
  input  logic [NSRC-1:0]            id_src_used,
  input  logic [REG_W-1:0]           id_dst,
  input  logic                       id_wen,
  input  logic                       id_load,
  output logic                       stall,
  output logic [NSRC-1:0][SEL_W-1:0] ex_fwd_sel,
  output logic [CNT_W-1:0]           stall_count
);

  sb_entry_t [NSTAGE-1:0] sb;
  logic [NSRC-1:0]        ex_used;
  regbits_t [NSRC-1:0]    ex_idx;
  logic                   hit;

  // Only loads too young to have data by LOAD_FWD block issue
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if ((k + 1 < LOAD_FWD) && sb[k].load &&
            src_match(id_src_used[i], id_src[i], sb[k])) begin
          hit = 1'b1;
        end
      end
    end
  end

  assign stall = id_valid & ~flush & hit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb          <= '0;
      ex_used     <= '0;
      ex_idx      <= '0;
      stall_count <= '0;
    end else if (advance) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        sb[k] <= sb[k-1];
      end
      if (flush || stall) begin
        sb[0]   <= '0;
        ex_used <= '0;
        ex_idx  <= '0;
      end else begin
        sb[0]   <= '{valid: id_valid, dst: id_dst,
                     wen: id_wen, load: id_load};
        ex_used <= id_src_used & {NSRC{id_valid}};
        ex_idx  <= id_valid ? id_src : '0;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_match #(
      .NSTAGE(NSTAGE),
      .SEL_W (SEL_W)
    ) u_match (
      .used(ex_used[i]),
      .idx (ex_idx[i]),
      .sb  (sb),
      .sel (ex_fwd_sel[i])
    );
  end

endmodule
